// File: rtl/pwm_generator_if.sv
// pwm_generator_if: register bus and PWM/interrupt outputs of the PWM generator
interface pwm_generator_if #(parameter int WIDTH = 32);
  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic             oe;
  logic [WIDTH-1:0] rdata;
  logic             int_clr;
  logic             intr;
  logic             pwm_out;
  modport master (output we, addr, wdata, oe, int_clr, input rdata, intr, pwm_out);
  modport slave  (input we, addr, wdata, oe, int_clr, output rdata, intr, pwm_out);
endinterface

// File: rtl/pwm_generator.sv
// pwm_generator: programmable continuous/one-shot PWM with shadowed period/duty and sticky period-end interrupt
module pwm_generator #(parameter int WIDTH = 32) (
  input logic             clk,
  input logic             rst,
  pwm_generator_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_d;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] period_s, duty_s, period_a, duty_a, cnt, cnt_d;
  logic             pwm, pwm_d, irq, load, set_int, clr_en, wrap;
  assign wrap = cnt == period_a - 1'b1;
  assign bus.pwm_out = pwm;
  assign bus.intr = irq;
  assign bus.rdata = !bus.oe ? '0 :
                     bus.addr == 2'd0 ? WIDTH'(ctrl) :
                     bus.addr == 2'd1 ? period_s :
                     bus.addr == 2'd2 ? duty_s : cnt;
  // Wrap and software-clear decisions use CTRL as it was before any same-edge write
  always_comb begin
    state_d = state;
    cnt_d = '0;
    pwm_d = 1'b0;
    load = 1'b0;
    set_int = 1'b0;
    clr_en = 1'b0;
    if (state == IDLE) begin
      if (ctrl[0] && period_s != '0) begin
        state_d = RUN;
        load = 1'b1;
        pwm_d = duty_s != '0;
      end
    end else if (!ctrl[0]) begin
      state_d = IDLE;
    end else if (wrap) begin
      set_int = ctrl[2];
      clr_en = ctrl[1];
      if (ctrl[1] || period_s == '0) begin
        state_d = IDLE;
      end else begin
        load = 1'b1;
        pwm_d = duty_s != '0;
      end
    end else begin
      cnt_d = cnt + 1'b1;
      pwm_d = cnt + 1'b1 < duty_a;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ctrl <= '0;
      period_s <= '0;
      duty_s <= '0;
      period_a <= '0;
      duty_a <= '0;
      cnt <= '0;
      pwm <= 1'b0;
      irq <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      pwm <= pwm_d;
      if (load) begin
        period_a <= period_s;
        duty_a <= duty_s;
      end
      if (bus.we && bus.addr == 2'd0) ctrl <= bus.wdata[2:0];
      if (clr_en) ctrl[0] <= 1'b0;
      if (bus.we && bus.addr == 2'd1) period_s <= bus.wdata;
      if (bus.we && bus.addr == 2'd2) duty_s <= bus.wdata;
      irq <= set_int | (irq & ~bus.int_clr);
    end
  end
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed scoreboard bench for pwm_generator
module tb_pwm_generator;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pwm_generator_if #(.WIDTH(W)) bus ();
  pwm_generator #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {string tag; logic [W-1:0] v;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input string t, input logic [W-1:0] v);
    exp_t e;
    e.tag = t;
    e.v = v;
    q.push_back(e);
  endtask
  task automatic chk(input logic [W-1:0] obs);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask
  task automatic rd(input string t, input logic [1:0] a, input logic [W-1:0] v);
    push(t, v);
    bus.addr = a;
    #1;
    chk(bus.rdata);
  endtask
  task automatic run_oneshot(input int len);
    int highs, first;
    highs = 0;
    first = -1;
    bus.int_clr = 1'b1;
    wr(2'd1, W'(len));
    bus.int_clr = 1'b0;
    wr(2'd2, W'(len));
    wr(2'd0, 32'd7);
    push("oneshot_high_cycles", W'(len));
    push("oneshot_first_rise", 32'd1);
    for (int k = 1; k <= len + 20; k++) begin
      tick();
      if (bus.pwm_out) begin
        highs++;
        if (first < 0) first = k;
      end
    end
    chk(W'(highs));
    chk(W'(first));
    rd("oneshot_ctrl", 2'd0, 32'd6);
    push("oneshot_int", 32'd1);
    chk(W'(bus.intr));
    rd("oneshot_count", 2'd3, 32'd0);
  endtask
  initial begin
    int cnt_e, duty_e;
    logic run_e;
    bus.we = 1'b0;
    bus.addr = 2'd0;
    bus.wdata = '0;
    bus.oe = 1'b0;
    bus.int_clr = 1'b0;
    tick();
    tick();
    push("reset_pwm", 32'd0);
    chk(W'(bus.pwm_out));
    push("reset_int", 32'd0);
    chk(W'(bus.intr));
    rst = 1'b1;
    bus.wdata = 32'hffff_ffff;
    push("rdata_oe0", 32'd0);
    #1;
    chk(bus.rdata);
    bus.oe = 1'b1;
    rd("reset_ctrl", 2'd0, 32'd0);
    rd("reset_period", 2'd1, 32'd0);
    rd("reset_duty", 2'd2, 32'd0);
    rd("reset_count", 2'd3, 32'd0);
    // PERIOD=0 with en set must stay idle
    wr(2'd0, 32'd1);
    repeat (5) tick();
    push("p0_pwm", 32'd0);
    chk(W'(bus.pwm_out));
    rd("p0_count", 2'd3, 32'd0);
    rd("p0_ctrl", 2'd0, 32'd1);
    wr(2'd0, 32'd0);
    // Continuous 10/3 with int clear, set-wins collision, shadow duty update, software disable
    wr(2'd1, 32'd10);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd5);
    bus.addr = 2'd3;
    for (int k = 1; k <= 55; k++) begin
      run_e = k <= 47;
      cnt_e = run_e ? (k - 1) % 10 : 0;
      duty_e = k >= 31 ? 8 : 3;
      push("cont_pwm", W'(run_e && cnt_e < duty_e));
      push("cont_int", W'((k >= 11 && k <= 13) || (k >= 21 && k <= 41)));
      push(k == 25 ? "cont_duty_shadow" : k == 47 ? "cont_ctrl" : "cont_count",
           k == 25 ? 32'd8 : k == 47 ? 32'd4 : W'(cnt_e));
      tick();
      chk(W'(bus.pwm_out));
      chk(W'(bus.intr));
      chk(bus.rdata);
      bus.int_clr = k == 13 || k == 20 || k == 41;
      bus.we = k == 24 || k == 46;
      bus.addr = k == 24 ? 2'd2 : k == 46 ? 2'd0 : 2'd3;
      bus.wdata = k == 24 ? 32'd8 : 32'd4;
    end
    bus.int_clr = 1'b0;
    bus.we = 1'b0;
    run_oneshot(1000);
    run_oneshot(7000);
    // DUTY=0: constant low, int still fires each period (set beats a held clear)
    wr(2'd1, 32'd10);
    wr(2'd2, 32'd0);
    bus.int_clr = 1'b1;
    wr(2'd0, 32'd5);
    for (int k = 1; k <= 25; k++) begin
      push("d0_pwm", 32'd0);
      push("d0_int", W'(k == 11 || k == 21));
      tick();
      chk(W'(bus.pwm_out));
      chk(W'(bus.intr));
    end
    bus.int_clr = 1'b0;
    wr(2'd0, 32'd0);
    tick();
    // DUTY>PERIOD: constant high, then async reset mid-period
    wr(2'd2, 32'd15);
    wr(2'd0, 32'd5);
    for (int k = 1; k <= 25; k++) begin
      push("d15_pwm", 32'd1);
      push("d15_int", W'(k >= 11));
      tick();
      chk(W'(bus.pwm_out));
      chk(W'(bus.intr));
    end
    rd("pre_rst_count", 2'd3, 32'd4);
    rst = 1'b0;
    #1;
    push("async_rst_pwm", 32'd0);
    chk(W'(bus.pwm_out));
    push("async_rst_int", 32'd0);
    chk(W'(bus.intr));
    rd("async_rst_ctrl", 2'd0, 32'd0);
    rd("async_rst_period", 2'd1, 32'd0);
    rd("async_rst_duty", 2'd2, 32'd0);
    rst = 1'b1;
    repeat (5) tick();
    push("post_rst_pwm", 32'd0);
    chk(W'(bus.pwm_out));
    rd("post_rst_count", 2'd3, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
